accumulator_control_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/instr_decoder.sv | 32 +++
 rtl/accumulator_control_unit.sv | 141 ++++++++++++++
 tb/tb_accumulator_control_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the accumulator machine: sequencer states,
// instruction classes, instruction opcodes, ALU opcodes and default widths.
package cpu_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int MEM_ADDR_W = 16;
  localparam int OPC_W      = 4;

  typedef enum logic [3:0] {
    FETCH, IREAD, ILATCH, DECODE, OPREAD, OPLATCH, EXEC, STORE, HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_MEM_RD, CL_MEM_WR, CL_REG, CL_BRANCH, CL_HALT, CL_ILLEGAL
  } iclass_e;

  localparam logic [OPC_W-1:0] OP_HALT  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND   = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR    = 4'h6;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'h7;
  localparam logic [OPC_W-1:0] OP_SHL   = 4'h8;
  localparam logic [OPC_W-1:0] OP_SHR   = 4'h9;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'hA;
  localparam logic [OPC_W-1:0] OP_JZ    = 4'hB;
  localparam logic [OPC_W-1:0] OP_LDI   = 4'hC;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode: instruction opcode -> ALU opcode and
// instruction class used by the sequencer's DECODE step.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [3:0]       alu_op,
  output iclass_e          iclass
);

  always_comb begin
    alu_op = ALU_ADD;
    iclass = CL_ILLEGAL;
    case (opcode)
      OP_HALT:  iclass = CL_HALT;
      OP_LOAD:  iclass = CL_MEM_RD;
      OP_STORE: iclass = CL_MEM_WR;
      OP_ADD:   begin iclass = CL_MEM_RD; alu_op = ALU_ADD; end
      OP_SUB:   begin iclass = CL_MEM_RD; alu_op = ALU_SUB; end
      OP_AND:   begin iclass = CL_MEM_RD; alu_op = ALU_AND; end
      OP_OR:    begin iclass = CL_MEM_RD; alu_op = ALU_OR;  end
      OP_XOR:   begin iclass = CL_MEM_RD; alu_op = ALU_XOR; end
      OP_SHL:   begin iclass = CL_REG;    alu_op = ALU_SHL; end
      OP_SHR:   begin iclass = CL_REG;    alu_op = ALU_SHR; end
      OP_JMP:   iclass = CL_BRANCH;
      OP_JZ:    iclass = CL_BRANCH;
      OP_LDI:   iclass = CL_REG;
      default:  iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/accumulator_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator machine.
// Define ILLEGAL_OPCODE_TRAP_EN to trap opcodes D-F into HALT with a sticky illegal_op flag.
module accumulator_control_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [3:0]            alu_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_result,
  output logic                  halted,
  output logic [ADDR_W-1:0]     pc_out,
`ifdef ILLEGAL_OPCODE_TRAP_EN
  output logic                  illegal_op,
`endif
  output logic [DATA_W-1:0]     acc_out
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0]   ir_q, ir_d, mbr_q, mbr_d, acc_q, acc_d;
  logic                illegal_q, illegal_d;

  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   operand;
  logic [3:0]          dec_alu_op;
  iclass_e             dec_class;

  assign opcode  = ir_q[DATA_W-1 -: OPC_W];
  assign operand = ir_q[ADDR_W-1:0];

  instr_decoder u_dec (
    .opcode (opcode),
    .alu_op (dec_alu_op),
    .iclass (dec_class)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= ADDR_W'(RESET_PC);
      mar_q     <= '0;
      ir_q      <= '0;
      mbr_q     <= '0;
      acc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      ir_q      <= ir_d;
      mbr_q     <= mbr_d;
      acc_q     <= acc_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mar_d     = mar_q;
    ir_d      = ir_q;
    mbr_d     = mbr_q;
    acc_d     = acc_q;
    illegal_d = illegal_q;
    alu_op    = ALU_ADD;
    case (state_q)
      FETCH: begin
        mar_d   = pc_q;
        state_d = IREAD;
      end
      IREAD:  state_d = ILATCH;
      ILATCH: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = DECODE;
      end
      DECODE: begin
        case (dec_class)
          CL_MEM_RD: begin mar_d = operand; state_d = OPREAD; end
          CL_MEM_WR: begin mar_d = operand; state_d = STORE;  end
          CL_REG:    state_d = EXEC;
          CL_BRANCH: begin
            if (opcode == OP_JMP || acc_q == '0) pc_d = operand;
            state_d = FETCH;
          end
          CL_HALT:   state_d = HALT;
          default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
            illegal_d = 1'b1;
            state_d   = HALT;
`else
            state_d   = FETCH;
`endif
          end
        endcase
      end
      OPREAD:  state_d = OPLATCH;
      OPLATCH: begin
        mbr_d   = mem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        alu_op = dec_alu_op;
        if (opcode == OP_LOAD)     acc_d = mbr_q;
        else if (opcode == OP_LDI) acc_d = DATA_W'(operand);
        else                       acc_d = alu_result;
        state_d = FETCH;
      end
      STORE:   state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Write enable is gated by reset so a reset landing on STORE never writes.
  assign mem_we    = (state_q == STORE) & reset;
  assign mem_addr  = MEM_ADDR_W'(mar_q);
  assign mem_wdata = acc_q;
  assign alu_a     = acc_q;
  assign alu_b     = mbr_q;
  assign halted    = (state_q == HALT);
  assign pc_out    = pc_q;
  assign acc_out   = acc_q;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  assign illegal_op = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Directed bench for accumulator_control_unit with a synchronous memory model,
// a reference ALU and a queue of expected results popped at each check point.
module tb_accumulator_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        halted;
  logic [11:0] pc_out;
  logic [15:0] acc_out;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic        illegal_op;
`endif

  logic [15:0] mem [0:4095];
  logic        tb_we = 1'b0;
  logic [11:0] tb_addr = '0;
  logic [15:0] tb_data = '0;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  accumulator_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .halted     (halted),
    .pc_out     (pc_out),
`ifdef ILLEGAL_OPCODE_TRAP_EN
    .illegal_op (illegal_op),
`endif
    .acc_out    (acc_out)
  );

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:0]];
  end

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0100: alu_result = alu_a << 1;
      4'b0101: alu_result = alu_a >> 1;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_mis++;
      $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    run(2);

    // Program: LOAD [010], ADD [011], STORE [012], HALT
    hold_reset();
    poke(12'h000, 16'h1010);
    poke(12'h001, 16'h3011);
    poke(12'h002, 16'h2012);
    poke(12'h003, 16'h0000);
    poke(12'h010, 16'h0005);
    poke(12'h011, 16'h0007);
    poke(12'h012, 16'hDEAD);
    expect_val("rst_pc", 32'h000);
    expect_val("rst_acc", 32'h0000);
    expect_val("rst_halted", 32'h0);
    expect_val("rst_mem_we", 32'h0);
    check(32'(pc_out));
    check(32'(acc_out));
    check(32'(halted));
    check(32'(mem_we));
    reset = 1'b1;
    expect_val("load_acc_at_6", 32'h0000);
    expect_val("load_acc_at_7", 32'h0005);
    expect_val("not_halted_22", 32'h0);
    expect_val("halted_23", 32'h1);
    expect_val("prog_acc", 32'h000C);
    expect_val("prog_mem012", 32'h000C);
    expect_val("prog_pc", 32'h004);
    expect_val("halt_hold_pc", 32'h004);
    expect_val("halt_hold_halted", 32'h1);
    run(6);  check(32'(acc_out));
    run(1);  check(32'(acc_out));
    run(15); check(32'(halted));
    run(1);  check(32'(halted));
    check(32'(acc_out));
    check(32'(mem[12'h012]));
    check(32'(pc_out));
    run(5);  check(32'(pc_out));
    check(32'(halted));

    // SUB underflow: LDI 3, SUB [010]=5
    hold_reset();
    poke(12'h000, 16'hC003);
    poke(12'h001, 16'h4010);
    poke(12'h002, 16'h0000);
    poke(12'h010, 16'h0005);
    reset = 1'b1;
    expect_val("sub_underflow", 32'hFFFE);
    run(12); check(32'(acc_out));

    // SHL of register: LDI 3, SHL
    hold_reset();
    poke(12'h000, 16'hC003);
    poke(12'h001, 16'h8000);
    poke(12'h002, 16'h0000);
    reset = 1'b1;
    expect_val("shl_acc", 32'h0006);
    run(10); check(32'(acc_out));

    // JZ taken: LDI 0, JMP 005, JZ 020
    hold_reset();
    poke(12'h000, 16'hC000);
    poke(12'h001, 16'hA005);
    poke(12'h005, 16'hB020);
    poke(12'h020, 16'h0000);
    poke(12'h006, 16'h0000);
    reset = 1'b1;
    expect_val("jmp_pc", 32'h005);
    expect_val("jz_taken_pc", 32'h020);
    run(9); check(32'(pc_out));
    run(4); check(32'(pc_out));

    // JZ not taken with ACC=1
    hold_reset();
    poke(12'h000, 16'hC001);
    reset = 1'b1;
    expect_val("jz_not_taken_pc", 32'h006);
    run(13); check(32'(pc_out));

    // PC wrap: JMP FFF, LDI 0AB at FFF
    hold_reset();
    poke(12'h000, 16'hAFFF);
    poke(12'hFFF, 16'hC0AB);
    reset = 1'b1;
    expect_val("jmp_fff_pc", 32'hFFF);
    expect_val("wrap_acc", 32'h00AB);
    expect_val("wrap_pc", 32'h000);
    run(4); check(32'(pc_out));
    run(5); check(32'(acc_out));
    check(32'(pc_out));

    // Reset asserted during STORE: LDI 77, STORE [030]
    hold_reset();
    poke(12'h000, 16'hC077);
    poke(12'h001, 16'h2030);
    poke(12'h002, 16'h0000);
    poke(12'h030, 16'h1234);
    reset = 1'b1;
    expect_val("store_we", 32'h1);
    expect_val("store_addr", 32'h0030);
    expect_val("store_we_in_reset", 32'h0);
    expect_val("store_word_kept", 32'h1234);
    expect_val("store_rst_pc", 32'h000);
    expect_val("store_rst_acc", 32'h0000);
    expect_val("restart_acc", 32'h0077);
    expect_val("restart_word_kept", 32'h1234);
    run(9); check(32'(mem_we));
    check(32'(mem_addr));
    reset = 1'b0;
    #1 check(32'(mem_we));
    run(1);
    check(32'(mem[12'h030]));
    check(32'(pc_out));
    check(32'(acc_out));
    reset = 1'b1;
    run(5); check(32'(acc_out));
    check(32'(mem[12'h030]));

    // Opcode E after LDI 42
    hold_reset();
    poke(12'h000, 16'hC042);
    poke(12'h001, 16'hE000);
    poke(12'h002, 16'h0000);
    reset = 1'b1;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    expect_val("illegal_halted", 32'h1);
    expect_val("illegal_flag", 32'h1);
    expect_val("illegal_pc", 32'h002);
    expect_val("illegal_acc", 32'h0042);
    run(9); check(32'(halted));
    check(32'(illegal_op));
    check(32'(pc_out));
    check(32'(acc_out));
`else
    expect_val("nop_halted", 32'h0);
    expect_val("nop_pc", 32'h002);
    expect_val("nop_acc", 32'h0042);
    expect_val("nop_then_halt", 32'h1);
    run(9); check(32'(halted));
    check(32'(pc_out));
    check(32'(acc_out));
    run(4); check(32'(halted));
`endif

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
